decode_stage: RTL and testbench

- Pipelined, parametrised successor to the combinational RV32 instruction decoder.
- Accepts fetched instruction words over a valid/ready handshake and decodes them in the same cycle.
- Stores the decoded control bundle in a DEPTH-entry FIFO and presents the head entry to the execute stage over a second valid/ready handshake.
- Adds illegal-instruction detection, optional M/CSR support, pipeline flush and a retire counter.

---
 rtl/decode_stage.sv | 188 ++++++++++++++++++
 tb/tb_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32 decode stage: decodes accepted fetch words in the cycle they arrive, buffers the
// control bundle in a DEPTH-entry FIFO and hands the head entry to execute.
module decode_stage #(
    parameter int DEPTH  = 2,
    parameter bit MUL_EN = 1'b1,
    parameter bit CSR_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [3:0]       out_class,
    output logic [2:0]       out_funct3,
    output logic             out_sub_arith,
    output logic [31:0]      out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_wb_en,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decoded_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_ALUI    = 4'd7,
        CLS_ALU     = 4'd8,
        CLS_MUL     = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_SYSTEM  = 4'd11,
        CLS_ILLEGAL = 4'd15
    } cls_e;

    typedef struct packed {
        logic [31:0] pc;
        cls_e        cls;
        logic [2:0]  funct3;
        logic        sub_arith;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wb_en;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           dec;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    // ---------------- combinational decode of the incoming word ----------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves one unassigned (no latches).
        dec        = '0;
        dec.pc     = in_pc;
        dec.funct3 = funct3;
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.rd     = in_instr[11:7];
        dec.cls    = CLS_ILLEGAL;

        // Every listed opcode ends in 2'b11, so a compressed/invalid low pair falls to default.
        case (opcode)
            7'b0110111: dec.cls = CLS_LUI;
            7'b0010111: dec.cls = CLS_AUIPC;
            7'b1101111: dec.cls = CLS_JAL;
            7'b1100111: dec.cls = CLS_JALR;
            7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) dec.cls = CLS_BRANCH;
            7'b0000011: if (funct3 != 3'b011 && funct3 < 3'b110) dec.cls = CLS_LOAD;
            7'b0100011: if (funct3 < 3'b011) dec.cls = CLS_STORE;
            7'b0010011: dec.cls = CLS_ALUI;
            7'b0110011: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000)
                    dec.cls = CLS_ALU;
                else if (funct7 == 7'b0000001 && MUL_EN)
                    dec.cls = CLS_MUL;
            end
            7'b0001111: dec.cls = CLS_FENCE;
            7'b1110011: if (CSR_EN) dec.cls = CLS_SYSTEM;
            default:    dec.cls = CLS_ILLEGAL;
        endcase

        case (dec.cls)
            CLS_LUI, CLS_AUIPC:
                dec.imm = {in_instr[31:12], 12'b0};
            CLS_JAL:
                dec.imm = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            CLS_JALR, CLS_LOAD, CLS_ALUI, CLS_SYSTEM:
                dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            CLS_BRANCH:
                dec.imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            CLS_STORE:
                dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            default:
                dec.imm = '0;
        endcase

        case (dec.cls)
            CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD,
            CLS_ALUI, CLS_ALU, CLS_MUL, CLS_SYSTEM: dec.wb_en = 1'b1;
            default:                                dec.wb_en = 1'b0;
        endcase

        dec.sub_arith = (dec.cls == CLS_ALU || dec.cls == CLS_ALUI) && in_instr[30];
    end

    // ---------------- FIFO control ----------------
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign in_ready  = ((count < FULL_COUNT) | pop) & ~flush & ~reset;
    assign push      = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            decoded_cnt <= '0;
        end else begin
            if (pop)
                decoded_cnt <= decoded_cnt + CNT_W'(1);
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: entry storage has no reset; the outputs are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= dec;
    end

    // ---------------- head entry, zero whenever nothing is held ----------------
    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_pc        = head.pc;
    assign out_class     = head.cls;
    assign out_funct3    = head.funct3;
    assign out_sub_arith = head.sub_arith;
    assign out_imm       = head.imm;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_rd        = head.rd;
    assign out_wb_en     = head.wb_en;
    assign out_illegal   = out_valid && (head.cls == CLS_ILLEGAL);

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected bundles are queued on accept and compared on pop.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_class;
    logic [2:0]  out_funct3;
    logic        out_sub_arith;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_wb_en;
    logic        out_illegal;
    logic [31:0] decoded_cnt;

    // Second instance: no M extension and a 3-bit counter to exercise wrap.
    logic        nm_in_ready, nm_out_valid, nm_sub_arith, nm_wb_en, nm_illegal;
    logic [31:0] nm_pc, nm_imm;
    logic [3:0]  nm_class;
    logic [2:0]  nm_funct3;
    logic [4:0]  nm_rs1, nm_rs2, nm_rd;
    logic [2:0]  nm_cnt;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_class(out_class),
        .out_funct3(out_funct3), .out_sub_arith(out_sub_arith), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .out_illegal(out_illegal), .decoded_cnt(decoded_cnt)
    );

    decode_stage #(.MUL_EN(1'b0), .CNT_W(3)) dut_nomul (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nm_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(nm_out_valid),
        .out_ready(out_ready), .out_pc(nm_pc), .out_class(nm_class),
        .out_funct3(nm_funct3), .out_sub_arith(nm_sub_arith), .out_imm(nm_imm),
        .out_rs1(nm_rs1), .out_rs2(nm_rs2), .out_rd(nm_rd), .out_wb_en(nm_wb_en),
        .out_illegal(nm_illegal), .decoded_cnt(nm_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        sub;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        wb;
    } exp_t;

    exp_t q[$];
    exp_t cur_exp;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] cls, input logic [2:0] f3, input logic sub,
                                input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic wb);
        exp_t e;
        e.pc = '0; e.cls = cls; e.f3 = f3; e.sub = sub; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.wb = wb;
        return e;
    endfunction

    // Scoreboard monitor: inputs change at posedge+1, so the negedge sees the edge values.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_pc", out_pc, e.pc);
                    check("sb_class", out_class, e.cls);
                    check("sb_funct3", out_funct3, e.f3);
                    check("sb_sub", out_sub_arith, e.sub);
                    check("sb_imm", out_imm, e.imm);
                    check("sb_rs1", out_rs1, e.rs1);
                    check("sb_rs2", out_rs2, e.rs2);
                    check("sb_rd", out_rd, e.rd);
                    check("sb_wb", out_wb_en, e.wb);
                    check("sb_illegal", out_illegal, e.cls == 4'd15);
                end
            end
            if (flush)
                q.delete();
            else if (in_valid && in_ready)
                q.push_back(cur_exp);
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        cur_exp  = e;
        cur_exp.pc = pc;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        bit ok = 1'b0;
        drive(instr, pc, e);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (!out_valid) break;
            @(posedge clk); #1;
        end
        check("drain_valid", out_valid, 0);
        check("drain_queue", q.size(), 0);
    endtask

    exp_t e_addi, e_beq, e_lui, e_sw, e_mul, e_jal, e_csr, e_sub, e_ld_bad, e_ill;

    initial begin
        e_addi   = mk(4'd7,  3'd0, 1'b0, 32'd5,        5'd0, 5'd5, 5'd1,  1'b1);
        e_beq    = mk(4'd4,  3'd0, 1'b0, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd29, 1'b0);
        e_lui    = mk(4'd0,  3'd5, 1'b0, 32'h12345000, 5'd8, 5'd3, 5'd1,  1'b1);
        e_sw     = mk(4'd6,  3'd2, 1'b0, 32'd4,        5'd2, 5'd1, 5'd4,  1'b0);
        e_mul    = mk(4'd9,  3'd0, 1'b0, 32'd0,        5'd1, 5'd2, 5'd3,  1'b1);
        e_jal    = mk(4'd2,  3'd0, 1'b0, 32'd8,        5'd0, 5'd8, 5'd1,  1'b1);
        e_csr    = mk(4'd11, 3'd2, 1'b0, 32'h300,      5'd0, 5'd0, 5'd10, 1'b1);
        e_sub    = mk(4'd8,  3'd0, 1'b1, 32'd0,        5'd1, 5'd2, 5'd0,  1'b1);
        e_ld_bad = mk(4'd15, 3'd3, 1'b0, 32'd0,        5'd0, 5'd0, 5'd0,  1'b0);
        e_ill    = mk(4'd15, 3'd0, 1'b0, 32'd0,        5'd0, 5'd0, 5'd0,  1'b0);

        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_low", in_ready, 0);
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_cnt", decoded_cnt, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_in_ready_high", in_ready, 1);

        // Single push with 1-cycle latency and no bypass
        out_ready = 1'b1;
        drive(32'h00500093, 32'h100, e_addi);
        @(negedge clk);
        check("no_bypass", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("latency1_valid", out_valid, 1);
        @(posedge clk); #1;
        check("after_pop_valid", out_valid, 0);
        check("cnt_after_1", decoded_cnt, 1);

        // Backpressure: fill, hold stable, then push into a full FIFO with a same-cycle pop
        out_ready = 1'b0;
        send(32'hFE000EE3, 32'h200, e_beq);
        send(32'h123450B7, 32'h204, e_lui);
        drive(32'h00112223, 32'h208, e_sw);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_pc", out_pc, 32'h200);
            check("hold_imm", out_imm, 32'hFFFFFFFC);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("full_pop_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("still_full", in_ready, 0);
        check("head_after_swap", out_pc, 32'h204);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();
        check("cnt_after_4", decoded_cnt, 4);

        // MUL with and without the M extension
        out_ready = 1'b0;
        send(32'h022081B3, 32'h300, e_mul);
        check("mul_en_class", out_class, 9);
        check("nomul_class", nm_class, 15);
        check("nomul_illegal", nm_illegal, 1);
        check("nomul_wb", nm_wb_en, 0);
        out_ready = 1'b1;
        wait_drain();

        // Mixed stream including illegal encodings
        send(32'h008000EF, 32'h400, e_jal);
        send(32'h30002573, 32'h404, e_csr);
        send(32'h40208033, 32'h408, e_sub);
        send(32'h00003003, 32'h40C, e_ld_bad);
        send(32'h00000010, 32'h410, e_ill);
        wait_drain();
        check("cnt_after_10", decoded_cnt, 10);
        check("nomul_cnt_wrap", nm_cnt, 3'd2);

        // Flush with a same-cycle push: push dropped, count unchanged
        out_ready = 1'b0;
        send(32'h00500093, 32'h500, e_addi);
        send(32'h00112223, 32'h504, e_sw);
        drive(32'h008000EF, 32'h508, e_jal);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_cnt", decoded_cnt, 10);
        repeat (2) @(posedge clk);
        #1;
        check("flush_no_ghost", out_valid, 0);

        // Flush with a same-cycle pop: the pop still counts
        send(32'h00500093, 32'h600, e_addi);
        send(32'h123450B7, 32'h604, e_lui);
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flush_pop_valid", out_valid, 0);
        check("flush_pop_cnt", decoded_cnt, 11);

        // Reset mid-stream with two entries held
        send(32'h40208033, 32'h700, e_sub);
        send(32'h00112223, 32'h704, e_sw);
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_cnt", decoded_cnt, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_class", out_class, 0);
        check("mid_rst_nomul_cnt", nm_cnt, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
